// File: rtl/mult_sequencer_if.sv
// rtl/mult_sequencer_if.sv - handshake, data and adder-stage signals of the shift-add multiplier sequencer
interface mult_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             run;
  logic             load_b;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] comp_out;
  logic             comp_out_x;
  logic [WIDTH-1:0] comp_a;
  logic [WIDTH-1:0] comp_s;
  logic             comp_sub;
  logic             comp_cin;
  logic [WIDTH-1:0] aval;
  logic [WIDTH-1:0] bval;
  logic             xval;
  logic             done;

  modport master (
    output run, load_b, din, comp_out, comp_out_x,
    input  comp_a, comp_s, comp_sub, comp_cin, aval, bval, xval, done
  );

  modport slave (
    input  run, load_b, din, comp_out, comp_out_x,
    output comp_a, comp_s, comp_sub, comp_cin, aval, bval, xval, done
  );
endinterface

// File: rtl/mult_sequencer.sv
// rtl/mult_sequencer.sv - X/A/B register stage and sequencer for the signed shift-add multiplier
// Define MULT_LATCH_S_EN to latch the multiplicand in CLR; otherwise comp_s follows din live.
module mult_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  mult_sequencer_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, CLR, ADD, SHIFT, HOLD} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             x_reg;
  logic             done_reg;

`ifdef MULT_LATCH_S_EN
  logic [WIDTH-1:0] s_reg;
  assign bus.comp_s = s_reg;
`else
  assign bus.comp_s = bus.din;
`endif

  assign bus.comp_a   = a_reg;
  // The final iteration weights the sign bit of B negatively, hence subtract.
  assign bus.comp_sub = (state == ADD) && (cnt == LAST);
  assign bus.comp_cin = 1'b0;
  assign bus.aval     = a_reg;
  assign bus.bval     = b_reg;
  assign bus.xval     = x_reg;
  assign bus.done     = done_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      x_reg    <= 1'b0;
      done_reg <= 1'b0;
`ifdef MULT_LATCH_S_EN
      s_reg    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.load_b) begin
            b_reg <= bus.din;
            a_reg <= '0;
            x_reg <= 1'b0;
          end else if (bus.run) begin
            state <= CLR;
          end
        end
        CLR: begin
          a_reg <= '0;
          x_reg <= 1'b0;
          cnt   <= '0;
`ifdef MULT_LATCH_S_EN
          s_reg <= bus.din;
`endif
          state <= ADD;
        end
        ADD: begin
          if (b_reg[0]) begin
            x_reg <= bus.comp_out_x;
            a_reg <= bus.comp_out;
          end
          state <= SHIFT;
        end
        SHIFT: begin
          a_reg <= {x_reg, a_reg[WIDTH-1:1]};
          b_reg <= {a_reg[0], b_reg[WIDTH-1:1]};
          if (cnt == LAST) begin
            state    <= HOLD;
            done_reg <= 1'b1;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= ADD;
          end
        end
        HOLD: begin
          // Run held high stays here so a long Run level cannot retrigger.
          if (!bus.run) begin
            state    <= IDLE;
            done_reg <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_sequencer.sv
// tb/tb_mult_sequencer.sv - directed scoreboard bench for mult_sequencer with a behavioural adder stage
module tb_mult_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [16:0] sb[$];
  logic [7:0]  b_model = 8'h00;
  logic [8:0]  sum;

  mult_sequencer_if #(.WIDTH(8)) bus ();

  mult_sequencer #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Nine-bit sign-extended adder/subtractor feeding the result back
  assign sum = bus.comp_sub ? ({bus.comp_a[7], bus.comp_a} - {bus.comp_s[7], bus.comp_s})
                            : ({bus.comp_a[7], bus.comp_a} + {bus.comp_s[7], bus.comp_s});
  assign bus.comp_out   = sum[7:0];
  assign bus.comp_out_x = sum[8];

  function automatic logic [16:0] prod(input logic [7:0] b, input logic [7:0] s);
    logic signed [16:0] bs, ss, p;
    bs = {{9{b[7]}}, b};
    ss = {{9{s[7]}}, s};
    p  = bs * ss;
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_b(input logic [7:0] v);
    @(negedge clk);
    bus.load_b = 1'b1;
    bus.din    = v;
    @(posedge clk);
    #1;
    check("load_b_val", 32'(bus.bval), 32'(v));
    check("load_b_clr", 32'({bus.xval, bus.aval}), 32'h0);
    @(negedge clk);
    bus.load_b = 1'b0;
    b_model    = v;
  endtask

  // mode 0: plain, 1: Load_B pulses during run, 2: toggle din mid-run
  task automatic run_mult(input string tag, input logic [7:0] s, input int mode, input bit zero_chk);
    int n, sub_cnt, sub_at;
    bit touched;
    logic [16:0] exp;
    @(negedge clk);
    bus.din = s;
    bus.run = 1'b1;
    sb.push_back(prod(b_model, s));
    n = 0; sub_cnt = 0; sub_at = 0; touched = 0;
    while (!bus.done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.comp_sub) begin
        sub_cnt++;
        sub_at = n;
      end
      if (zero_chk && (bus.aval != 8'h00 || bus.xval)) touched = 1;
      if (mode == 1) bus.load_b = (n >= 6 && n <= 9);
      if (mode == 2 && n == 5) bus.din = ~s;
    end
    bus.load_b = 1'b0;
    exp = sb.pop_front();
    check({tag, "_done"}, 32'(bus.done), 32'h1);
    check({tag, "_latency"}, 32'(n), 32'd18);
    check({tag, "_result"}, 32'({bus.xval, bus.aval, bus.bval}), 32'(exp));
    check({tag, "_sub_count"}, 32'(sub_cnt), 32'd1);
    check({tag, "_sub_edge"}, 32'(sub_at), 32'd16);
    if (zero_chk) check({tag, "_acc_untouched"}, 32'(touched), 32'h0);
    b_model = exp[7:0];
  endtask

  task automatic release_run(input string tag);
    @(negedge clk);
    bus.run = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_done_fall"}, 32'(bus.done), 32'h0);
  endtask

  initial begin
    logic [16:0] held;
    bus.run    = 1'b0;
    bus.load_b = 1'b0;
    bus.din    = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a", 32'(bus.aval), 32'h0);
    check("rst_b", 32'(bus.bval), 32'h0);
    check("rst_x", 32'(bus.xval), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_sub", 32'(bus.comp_sub), 32'h0);
    check("rst_cin", 32'(bus.comp_cin), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Load_B wins over Run while both are high
    @(negedge clk);
    bus.load_b = 1'b1;
    bus.run    = 1'b1;
    bus.din    = 8'h3C;
    repeat (20) @(posedge clk);
    #1;
    check("prio_no_run", 32'(bus.done), 32'h0);
    check("prio_b", 32'(bus.bval), 32'h3C);
    @(negedge clk);
    bus.load_b = 1'b0;
    bus.run    = 1'b0;
    b_model    = 8'h3C;
    repeat (2) @(posedge clk);

    load_b(8'hC5);
    run_mult("neg413", 8'h07, 0, 0);
    check("neg413_xab", 32'({bus.xval, bus.aval, bus.bval}), 32'h1FE63);
    release_run("neg413");
    run_mult("reuse_b", 8'h02, 0, 0);
    check("reuse_b_xab", 32'({bus.xval, bus.aval, bus.bval}), 32'h000C6);
    release_run("reuse_b");

    load_b(8'h80);
    run_mult("min_min", 8'h80, 0, 0);
    check("min_min_xab", 32'({bus.xval, bus.aval, bus.bval}), 32'h04000);
    release_run("min_min");

    load_b(8'h00);
    run_mult("zero_b", 8'h55, 0, 1);
    release_run("zero_b");

    // Run held 40 cycles with Load_B pulses in the run and in HOLD
    load_b(8'h0B);
    run_mult("hold", 8'hF3, 1, 0);
    held = {bus.xval, bus.aval, bus.bval};
    check("hold_xab", 32'(held), 32'h1FF71);
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      bus.load_b = (i % 3 == 0);
      bus.din    = 8'hAA;
    end
    @(posedge clk);
    #1;
    check("hold_done_high", 32'(bus.done), 32'h1);
    check("hold_frozen", 32'({bus.xval, bus.aval, bus.bval}), 32'(held));
    @(negedge clk);
    bus.load_b = 1'b0;
    release_run("hold");
    check("hold_idle_b", 32'(bus.bval), 32'(held[7:0]));

    // Asynchronous reset right after edge 9 of a multiply
    load_b(8'h05);
    @(negedge clk);
    bus.din = 8'h09;
    bus.run = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_a", 32'(bus.aval), 32'h0);
    check("mid_rst_b", 32'(bus.bval), 32'h0);
    check("mid_rst_x", 32'(bus.xval), 32'h0);
    check("mid_rst_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    rst     = 1'b0;
    bus.run = 1'b0;
    b_model = 8'h00;
    repeat (2) @(posedge clk);
    load_b(8'h03);
`ifdef MULT_LATCH_S_EN
    run_mult("post_rst", 8'h03, 2, 0);
`else
    run_mult("post_rst", 8'h03, 0, 0);
`endif
    check("post_rst_b", 32'(bus.bval), 32'h09);
    release_run("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Sequencing and register stage for the 8-bit signed shift-add multiplier. It holds the X, A and B product registers and latches the multiplicand S. It drives the adder/subtractor stage (operands, sub select) and captures that stage's 9-bit result. It runs eight add/arithmetic-shift iterations per Run, subtracting on the last, and leaves the signed product in A:B, with X as the sign extension.

## Interface
- WIDTH, 8, operand width; the iteration count equals WIDTH
- Clk  in  1  system clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- Run  in  1  level; starts a multiply when sampled high in IDLE
- Load_B  in  1  level; in IDLE: B <= Din, A <= 0, X <= 0
- Din  in  WIDTH  switch input; B load value, and S source
- comp_out  in  WIDTH  low WIDTH bits of adder result
- comp_out_x  in  1  bit WIDTH (sign) of the sign-extended result
- comp_a  out  WIDTH  equals A
- comp_s  out  WIDTH  multiplicand fed to the adder
- comp_sub  out  1  1 selects A - S
- comp_cin  out  1  tied 0; subtract carry-in is internal to the adder stage
- Aval, Bval  out  WIDTH  A and B registers
- Xval  out  1  X register
- Done  out  1  high while in HOLD

## Operation
- States: IDLE, CLR, ADD, SHIFT, HOLD. Counter cnt has $clog2(WIDTH) bits.
- IDLE:
  - Load_B=1 → load B, clear A and X, stay in IDLE.
  - else Run=1 → CLR. Load_B has priority over Run.
- CLR (1 cycle): A <= 0, X <= 0, S_reg <= Din, cnt <= 0 → ADD. B is retained, so a second Run multiplies the previous low byte by the new S.
- ADD (1 cycle):
  - B[0]=1 → {X,A} <= {comp_out_x, comp_out}.
  - B[0]=0 → hold.
  - comp_sub=1 only when cnt==WIDTH-1; otherwise 0.
  - Always → SHIFT.
- SHIFT (1 cycle): arithmetic right shift of X:A:B: A <= {X, A[WIDTH-1:1]}, B <= {A[0], B[WIDTH-1:1]}, X unchanged.
  - cnt==WIDTH-1 → HOLD.
  - else cnt <= cnt+1 → ADD.
- HOLD: Done=1, registers frozen. Run=0 → IDLE. Load_B ignored.
- Load_B and Run are ignored outside IDLE (Load_B also outside IDLE's rule above). Din changes during CLR..HOLD are governed by Configuration.
- Result: {X,A,B} = sign-extended two's-complement product of B_initial × S_reg. This holds for all inputs, including -128 × -128.

## Timing
- Reset values: state IDLE, X=0, A=0, B=0, S_reg=0, cnt=0, Done=0, comp_sub=0, comp_cin=0.
- Run sampled high at edge 0 → CLR acts at edge 1.
- ADD of iteration i at edge 2+2i; SHIFT at edge 3+2i.
- Done rises after edge 17 (WIDTH=8): 2·WIDTH+1 edges from the Run sample.
- Done stays high until the first edge with Run=0; it falls on that edge.
- Run held high through HOLD does not retrigger.
- comp_a, comp_s and comp_sub are combinational from registered state and stable for the whole ADD cycle. The adder stage is combinational, so there is no added latency.
- Reset asserted mid-operation: immediate return to IDLE, all registers cleared, Done=0; no partial product survives.

## Configuration
- MULT_LATCH_S_EN defined: comp_s = S_reg, captured in CLR. Din changes during the multiply do not affect the result.
- Undefined: S_reg is removed and comp_s = Din live every cycle. The result uses whatever Din is during each ADD cycle.

## Test plan
- Load_B with Din=0xC5, then Run with Din=0x07 → Done after 17 edges; X=1, A=0xFE, B=0x63 (-413).
- Immediately after that case, release Run, then Run with Din=0x02 and no Load_B → X=0, A=0x00, B=0xC6 (99×2).
- Load_B with Din=0x80, then Run with Din=0x80 → X=0, A=0x40, B=0x00 (16384). comp_sub=1 only in the ADD cycle at edge 16.
- Load_B with Din=0x00, then Run with Din=0x55 → A=0x00, B=0x00, X=0; {X,A} untouched in every ADD.
- Run held high 40 cycles → exactly one multiply; Done stays 1 until Run drops, then IDLE. Load_B pulses during the run are ignored.
- Reset pulse at edge 9 of a multiply → all outputs 0 the same cycle, IDLE. A subsequent 0x03×0x03 yields B=0x09. With MULT_LATCH_S_EN, toggling Din mid-run leaves that result unchanged.
